id_alu_ctrl: RTL and testbench



---
 rtl/id_alu_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 tb/tb_id_alu_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_alu_ctrl.sv
// id_alu_ctrl - RV32I decode-stage register feeding the ALU operation interface.
//
// Takes a fetched instruction and its PC, decodes the ALU operation, operand
// selects, immediate, register indices and control strobes, and registers
// the bundle. A valid/ready handshake sits on both sides with one cycle of
// latency and full throughput. Flush empties the stage and drops the
// instruction offered in the same cycle.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   in_valid/in_ready fetch-side handshake; in_ready = ~out_valid | out_ready
//   instr, pc         raw instruction word and its address
//   flush             discard the held bundle and the incoming instruction
//   out_valid/ready   execute-side handshake
//   out_pc            registered pc
//   ALU_Operation     0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA 8 SLT 9 SLTU
//   ALUSrcA           00 rs1, 01 pc, 10 zero
//   ALUSrcB           0 rs2, 1 Imm
//   Imm               sign-extended immediate in the format of the opcode
//   rs1/rs2/rd_addr   register indices taken from the instruction fields
//   funct3            passed through for branch/load/store sizing
//   RegWrite, MemRead, MemWrite, Branch, Jump   control strobes
//   illegal           instruction is not decodable as RV32I
//
// Only XLEN = 32 is supported.
module id_alu_ctrl #(
   parameter int unsigned XLEN     = 32,
   parameter logic [3:0]  RESET_OP = 4'b0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [3:0]      ALU_Operation,
   output logic [1:0]      ALUSrcA,
   output logic            ALUSrcB,
   output logic [XLEN-1:0] Imm,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   output logic [4:0]      rd_addr,
   output logic [2:0]      funct3,
   output logic            RegWrite,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            Branch,
   output logic            Jump,
   output logic            illegal
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   localparam logic [1:0] SRCA_RS1  = 2'b00;
   localparam logic [1:0] SRCA_PC   = 2'b01;
   localparam logic [1:0] SRCA_ZERO = 2'b10;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_e;

   // funct3 to ALU operation for OP / OP-IMM; alt selects SUB / SRA.
   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   // Immediate assembly; ins holds instr[31:7], the union of all immediate bits.
   function automatic logic signed [31:0] imm_gen(input imm_fmt_e fmt, input logic [31:7] ins);
      logic signed [31:0] imm;
      case (fmt)
         IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
         IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         IMM_U:   imm = {ins[31:12], 12'b0};
         IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       f7_std;
   logic       f7_alt;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign f7_std = (f7 == 7'b0000000);
   assign f7_alt = (f7 == 7'b0100000);

   logic [3:0]         dec_op;
   logic [1:0]         dec_srca;
   logic               dec_srcb;
   imm_fmt_e           dec_fmt;
   logic signed [31:0] dec_imm;
   logic               dec_rw;
   logic               dec_mr;
   logic               dec_mw;
   logic               dec_br;
   logic               dec_jp;
   logic               dec_ill;

   // Combinational decode of the instruction offered this cycle
   always_comb begin
      dec_op   = ALU_ADD;
      dec_srca = SRCA_RS1;
      dec_srcb = 1'b0;
      dec_fmt  = IMM_NONE;
      dec_rw   = 1'b0;
      dec_mr   = 1'b0;
      dec_mw   = 1'b0;
      dec_br   = 1'b0;
      dec_jp   = 1'b0;
      dec_ill  = 1'b0;

      case (opcode)
         OPC_OP: begin
            dec_op  = alu_from_f3(f3, instr[30]);
            dec_rw  = 1'b1;
            // funct7 0100000 only encodes SUB and SRA
            dec_ill = ~(f7_std | (f7_alt & ((f3 == 3'b000) | (f3 == 3'b101))));
         end
         OPC_OPIMM: begin
            // ADDI has no SUB form: instr[30] is immediate data there
            dec_op   = alu_from_f3(f3, (f3 == 3'b101) & instr[30]);
            dec_srcb = 1'b1;
            dec_fmt  = IMM_I;
            dec_rw   = 1'b1;
            // only the shift forms constrain the upper bits
            if (f3 == 3'b001) begin
               dec_ill = ~f7_std;
            end else if (f3 == 3'b101) begin
               dec_ill = ~(f7_std | f7_alt);
            end
         end
         OPC_LOAD: begin
            dec_srcb = 1'b1;
            dec_fmt  = IMM_I;
            dec_mr   = 1'b1;
            dec_rw   = 1'b1;
            // LB LH LW LBU LHU only
            dec_ill  = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
         end
         OPC_STORE: begin
            dec_srcb = 1'b1;
            dec_fmt  = IMM_S;
            dec_mw   = 1'b1;
            // SB SH SW only
            dec_ill  = f3[2] | (f3[1:0] == 2'b11);
         end
         OPC_BRANCH: begin
            // BEQ/BNE compare by subtraction, signed/unsigned for the rest
            case (f3[2:1])
               2'b00:   dec_op = ALU_SUB;
               2'b10:   dec_op = ALU_SLT;
               2'b11:   dec_op = ALU_SLTU;
               default: dec_op = ALU_ADD;
            endcase
            dec_fmt = IMM_B;
            dec_br  = 1'b1;
            dec_ill = (f3[2:1] == 2'b01);
         end
         OPC_LUI: begin
            dec_srca = SRCA_ZERO;
            dec_srcb = 1'b1;
            dec_fmt  = IMM_U;
            dec_rw   = 1'b1;
         end
         OPC_AUIPC: begin
            dec_srca = SRCA_PC;
            dec_srcb = 1'b1;
            dec_fmt  = IMM_U;
            dec_rw   = 1'b1;
         end
         OPC_JAL: begin
            dec_srca = SRCA_PC;
            dec_srcb = 1'b1;
            dec_fmt  = IMM_J;
            dec_jp   = 1'b1;
            dec_rw   = 1'b1;
         end
         OPC_JALR: begin
            dec_srcb = 1'b1;
            dec_fmt  = IMM_I;
            dec_jp   = 1'b1;
            dec_rw   = 1'b1;
            dec_ill  = (f3 != 3'b000);
         end
         default: begin
            dec_ill = 1'b1;
         end
      endcase

      // 16-bit compressed encodings are outside RV32I
      if (instr[1:0] != 2'b11) begin
         dec_ill = 1'b1;
      end

      // an illegal instruction still flows down as a harmless ADD
      if (dec_ill) begin
         dec_op = ALU_ADD;
         dec_rw = 1'b0;
         dec_mr = 1'b0;
         dec_mw = 1'b0;
         dec_br = 1'b0;
         dec_jp = 1'b0;
      end
   end

   assign dec_imm = imm_gen(dec_fmt, instr[31:7]);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [3:0]      op_q, op_d;
   logic [1:0]      srca_q, srca_d;
   logic            srcb_q, srcb_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [4:0]      rs1_q, rs1_d;
   logic [4:0]      rs2_q, rs2_d;
   logic [4:0]      rd_q, rd_d;
   logic [2:0]      f3_q, f3_d;
   logic            rw_q, rw_d;
   logic            mr_q, mr_d;
   logic            mw_q, mw_d;
   logic            br_q, br_d;
   logic            jp_q, jp_d;
   logic            ill_q, ill_d;

   logic load;

   assign in_ready = ~valid_q | out_ready;
   assign load     = in_valid & in_ready & ~flush;

   // Next-state: flush beats load, load beats drain; otherwise hold
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      op_d    = op_q;
      srca_d  = srca_q;
      srcb_d  = srcb_q;
      imm_d   = imm_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      rd_d    = rd_q;
      f3_d    = f3_q;
      rw_d    = rw_q;
      mr_d    = mr_q;
      mw_d    = mw_q;
      br_d    = br_q;
      jp_d    = jp_q;
      ill_d   = ill_q;

      if (flush) begin
         valid_d = 1'b0;
         op_d    = RESET_OP;
         rw_d    = 1'b0;
         mr_d    = 1'b0;
         mw_d    = 1'b0;
         br_d    = 1'b0;
         jp_d    = 1'b0;
         ill_d   = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         pc_d    = pc;
         op_d    = dec_op;
         srca_d  = dec_srca;
         srcb_d  = dec_srcb;
         imm_d   = dec_imm;
         rs1_d   = instr[19:15];
         rs2_d   = instr[24:20];
         rd_d    = instr[11:7];
         f3_d    = f3;
         rw_d    = dec_rw;
         mr_d    = dec_mr;
         mw_d    = dec_mw;
         br_d    = dec_br;
         jp_d    = dec_jp;
         ill_d   = dec_ill;
      end else if (out_ready) begin
         // bundle consumed (or stage already empty); payload may stay
         valid_d = 1'b0;
      end
   end

   // Decode -> execute boundary register
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         op_q    <= RESET_OP;
         srca_q  <= SRCA_RS1;
         srcb_q  <= 1'b0;
         imm_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         f3_q    <= '0;
         rw_q    <= 1'b0;
         mr_q    <= 1'b0;
         mw_q    <= 1'b0;
         br_q    <= 1'b0;
         jp_q    <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         op_q    <= op_d;
         srca_q  <= srca_d;
         srcb_q  <= srcb_d;
         imm_q   <= imm_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         f3_q    <= f3_d;
         rw_q    <= rw_d;
         mr_q    <= mr_d;
         mw_q    <= mw_d;
         br_q    <= br_d;
         jp_q    <= jp_d;
         ill_q   <= ill_d;
      end
   end

   assign out_valid     = valid_q;
   assign out_pc        = pc_q;
   assign ALU_Operation = op_q;
   assign ALUSrcA       = srca_q;
   assign ALUSrcB       = srcb_q;
   assign Imm           = imm_q;
   assign rs1_addr      = rs1_q;
   assign rs2_addr      = rs2_q;
   assign rd_addr       = rd_q;
   assign funct3        = f3_q;
   assign RegWrite      = rw_q;
   assign MemRead       = mr_q;
   assign MemWrite      = mw_q;
   assign Branch        = br_q;
   assign Jump          = jp_q;
   assign illegal       = ill_q;

endmodule

// File: tb/tb_id_alu_ctrl.sv
// Scoreboard bench for id_alu_ctrl: directed vectors, handshake corner cases
// and a randomized stream, each expected bundle produced by a reference model.
module tb_id_alu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [3:0]  ALU_Operation;
   logic [1:0]  ALUSrcA;
   logic        ALUSrcB;
   logic [31:0] Imm;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic [2:0]  funct3;
   logic        RegWrite, MemRead, MemWrite, Branch, Jump, illegal;

   always #5 clk = ~clk;

   id_alu_ctrl #(.XLEN(32), .RESET_OP(4'b0000)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc(pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .ALU_Operation(ALU_Operation),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .Imm(Imm), .rs1_addr(rs1_addr),
      .rs2_addr(rs2_addr), .rd_addr(rd_addr), .funct3(funct3),
      .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .Branch(Branch), .Jump(Jump), .illegal(illegal)
   );

   typedef struct packed {
      logic [3:0]  op;
      logic [1:0]  srca;
      logic        srcb;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        br;
      logic        jp;
      logic        ill;
      logic [31:0] pc;
   } bundle_t;

   typedef struct packed {
      bundle_t exp;
      bundle_t mask;
   } sb_item_t;

   sb_item_t sb[$];
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_b(input string nm, input bundle_t act, input bundle_t exp, input bundle_t m);
      n_cmp++;
      if ((act & m) !== (exp & m)) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (mask %h)", nm, act, exp, m);
      end
   endtask

   function automatic bundle_t dut_bundle();
      bundle_t b;
      b.op = ALU_Operation; b.srca = ALUSrcA; b.srcb = ALUSrcB; b.imm = Imm;
      b.rs1 = rs1_addr; b.rs2 = rs2_addr; b.rd = rd_addr; b.f3 = funct3;
      b.rw = RegWrite; b.mr = MemRead; b.mw = MemWrite; b.br = Branch;
      b.jp = Jump; b.ill = illegal; b.pc = out_pc;
      return b;
   endfunction

   // Reference model: RV32I decode rules written with integer arithmetic.
   function automatic void model(input logic [31:0] ins, input logic [31:0] p,
                                 output bundle_t e, output bundle_t m);
      int f3, f7, opc, hi;
      int immI, immS, immB, immU, immJ;
      bit ok;
      int alu_tbl[8] = '{0, 5, 8, 9, 4, 6, 3, 2};
      f3  = int'(ins[14:12]);
      f7  = int'(ins[31:25]);
      opc = int'(ins[6:0]);
      immI = $signed(ins) >>> 20;
      hi   = $signed(ins) >>> 25;
      immS = hi * 32 + int'(ins[11:7]);
      hi   = $signed(ins) >>> 31;
      immB = hi * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      immU = int'(ins) & 32'hFFFFF000;
      immJ = hi * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      e = '0;
      m = '1;
      e.pc = p; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.f3 = ins[14:12];
      ok = 1'b1;
      case (opc)
         'h33: begin
            ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
            e.op = 4'(alu_tbl[f3] + ((f7 == 'h20) ? 1 : 0));
            e.rw = 1'b1;
            m.imm = '0;
         end
         'h13: begin
            if (f3 == 1) ok = (f7 == 0);
            else if (f3 == 5) ok = (f7 == 0) || (f7 == 'h20);
            e.op = 4'(alu_tbl[f3] + ((f3 == 5 && f7 == 'h20) ? 1 : 0));
            e.srcb = 1'b1; e.imm = immI; e.rw = 1'b1;
         end
         'h03: begin
            ok = f3 inside {0, 1, 2, 4, 5};
            e.srcb = 1'b1; e.imm = immI; e.mr = 1'b1; e.rw = 1'b1;
         end
         'h23: begin
            ok = (f3 <= 2);
            e.srcb = 1'b1; e.imm = immS; e.mw = 1'b1;
         end
         'h63: begin
            ok = (f3 != 2) && (f3 != 3);
            e.op = (f3 < 2) ? 4'd1 : (f3 < 6) ? 4'd8 : 4'd9;
            e.imm = immB; e.br = 1'b1;
         end
         'h37: begin e.srca = 2'b10; e.srcb = 1'b1; e.imm = immU; e.rw = 1'b1; end
         'h17: begin e.srca = 2'b01; e.srcb = 1'b1; e.imm = immU; e.rw = 1'b1; end
         'h6F: begin e.srca = 2'b01; e.srcb = 1'b1; e.imm = immJ; e.jp = 1'b1; e.rw = 1'b1; end
         'h67: begin
            ok = (f3 == 0);
            e.srcb = 1'b1; e.imm = immI; e.jp = 1'b1; e.rw = 1'b1;
         end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         e.op = 4'd0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0; e.jp = 1'b0;
         e.ill = 1'b1;
         m = '0;
         m.op = '1; m.rw = 1'b1; m.mr = 1'b1; m.mw = 1'b1; m.br = 1'b1; m.jp = 1'b1;
         m.ill = 1'b1; m.pc = '1;
      end
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [2:0]  f;
      int k;
      r = $urandom;
      k = $urandom_range(0, 10);
      case (k)
         0: begin r[6:0] = 7'h33; r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00; end
         1: begin
            r[6:0] = 7'h13;
            if (r[13:12] == 2'b01) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
         end
         2: begin
            r[6:0] = 7'h03;
            f = 3'($urandom_range(0, 4));
            if (f >= 3'd3) f = f + 3'd1;
            r[14:12] = f;
         end
         3: begin r[6:0] = 7'h23; r[14:12] = 3'($urandom_range(0, 2)); end
         4: r[6:0] = 7'h63;
         5: r[6:0] = 7'h37;
         6: r[6:0] = 7'h17;
         7: r[6:0] = 7'h6F;
         8: begin
            r[6:0] = 7'h67;
            if ($urandom_range(0, 3) != 0) r[14:12] = 3'b000;
         end
         9: r[6:0] = 7'h33;
         default: ;
      endcase
      return r;
   endfunction

   // One clock of stimulus; the expected bundle is queued when a load happens.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic rdy, input logic fl);
      sb_item_t it;
      in_valid = v; instr = ins; pc = p; out_ready = rdy; flush = fl;
      @(negedge clk);
      if (v && in_ready && !fl && !rst) begin
         model(ins, p, it.exp, it.mask);
         sb.push_back(it);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops and compares on every accepted output, checks stall stability
   initial begin : monitor
      bundle_t  snap, cur;
      sb_item_t it;
      bit prev_stall;
      bit after_flush;
      prev_stall  = 1'b0;
      after_flush = 1'b0;
      snap = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall  = 1'b0;
            after_flush = 1'b0;
         end else begin
            cur = dut_bundle();
            if (after_flush) chk("flush_valid", 32'(out_valid), 32'd0);
            if (prev_stall) begin
               chk("stall_valid", 32'(out_valid), 32'd1);
               chk_b("stall_hold", cur, snap, '1);
            end
            chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid && flush) begin
               if (sb.size() > 0) it = sb.pop_front();
            end else if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL sb_empty: got bundle %h expected no output", cur);
               end else begin
                  it = sb.pop_front();
                  chk_b("bundle", cur, it.exp, it.mask);
               end
            end
            prev_stall  = out_valid && !out_ready && !flush;
            snap        = cur;
            after_flush = flush;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL timeout: got no end of run expected finish");
      $fatal(1, "timeout");
   end

   initial begin : driver
      logic [31:0] p;
      rst = 1'b1; in_valid = 1'b1; instr = 32'h40208133; pc = 32'h0;
      out_ready = 1'b1; flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk("rst_valid", 32'(out_valid), 32'd0);
         chk("rst_op", 32'(ALU_Operation), 32'd0);
         chk("rst_strobes", 32'({RegWrite, MemRead, MemWrite, Branch, Jump, illegal}), 32'd0);
         chk("rst_imm", Imm, 32'd0);
         chk("rst_pc", out_pc, 32'd0);
      end
      rst = 1'b0;

      // directed decode vectors, back to back
      cycle(1'b1, 32'h40208133, 32'h100, 1'b1, 1'b0);
      chk("sub_valid", 32'(out_valid), 32'd1);
      chk("sub_op", 32'(ALU_Operation), 32'd1);
      chk("sub_srca", 32'(ALUSrcA), 32'd0);
      chk("sub_srcb", 32'(ALUSrcB), 32'd0);
      chk("sub_rd", 32'(rd_addr), 32'd2);
      chk("sub_rw", 32'(RegWrite), 32'd1);
      chk("sub_pc", out_pc, 32'h100);
      cycle(1'b1, 32'h4030D093, 32'h104, 1'b1, 1'b0);
      chk("srai_op", 32'(ALU_Operation), 32'd7);
      chk("srai_imm", 32'(Imm[4:0]), 32'd3);
      chk("srai_srcb", 32'(ALUSrcB), 32'd1);
      cycle(1'b1, 32'hFFF00093, 32'h108, 1'b1, 1'b0);
      chk("addi_op", 32'(ALU_Operation), 32'd0);
      chk("addi_imm", Imm, 32'hFFFFFFFF);
      cycle(1'b1, 32'h0020E463, 32'h10C, 1'b1, 1'b0);
      chk("bltu_op", 32'(ALU_Operation), 32'd9);
      chk("bltu_br", 32'(Branch), 32'd1);
      chk("bltu_imm", Imm, 32'd8);
      cycle(1'b1, 32'h123450B7, 32'h110, 1'b1, 1'b0);
      chk("lui_srca", 32'(ALUSrcA), 32'd2);
      chk("lui_imm", Imm, 32'h12345000);
      cycle(1'b1, 32'h0000007F, 32'h114, 1'b1, 1'b0);
      chk("ill_valid", 32'(out_valid), 32'd1);
      chk("ill_flag", 32'(illegal), 32'd1);
      chk("ill_rw", 32'(RegWrite), 32'd0);
      chk("ill_mw", 32'(MemWrite), 32'd0);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("drain_valid", 32'(out_valid), 32'd0);

      // stall for 3 cycles, then release
      cycle(1'b1, 32'h00308093, 32'h200, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 32'h00110113, 32'h204, 1'b0, 1'b0);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_pc", out_pc, 32'h200);
      end
      cycle(1'b1, 32'h00110113, 32'h204, 1'b1, 1'b0);
      chk("release_pc", out_pc, 32'h204);
      chk("release_valid", 32'(out_valid), 32'd1);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // flush during a stall with an instruction offered
      cycle(1'b1, 32'h00A00513, 32'h300, 1'b0, 1'b0);
      cycle(1'b1, 32'h00B00593, 32'h304, 1'b0, 1'b0);
      cycle(1'b1, 32'h00B00593, 32'h304, 1'b0, 1'b1);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_strobes", 32'({RegWrite, MemRead, MemWrite, Branch, Jump}), 32'd0);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("flush_no_emit", 32'(out_valid), 32'd0);

      // 8 back-to-back instructions give 8 consecutive outputs
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, rand_instr(), 32'h400 + 32'(i * 4), 1'b1, 1'b0);
         chk("b2b_valid", 32'(out_valid), 32'd1);
      end
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("b2b_end", 32'(out_valid), 32'd0);

      // randomized traffic with stalls and occasional flushes
      for (int i = 0; i < 400; i++) begin
         logic v, r, f;
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 3) != 0);
         f = !r && ($urandom_range(0, 7) == 0);
         p = $urandom & 32'hFFFFFFFC;
         cycle(v, rand_instr(), p, r, f);
      end

      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
